// File: rtl/gps_ctrl_pkg.sv
// Shared types and widths for the GPS round scheduler and the requester-side glue.
package gps_ctrl_pkg;

  localparam int GPS_SV_NUM_W = 6;
  localparam int GPS_CA_W     = 13;
  localparam int GPS_CODE_W   = 128;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARB      = 3'd1,
    ST_CORE_RST = 3'd2,
    ST_START    = 3'd3,
    ST_WAIT     = 3'd4,
    ST_RESP     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_TIMEOUT = 2'd1,
    RSP_NOKEY   = 2'd2,
    RSP_RSVD    = 2'd3
  } gps_rsp_status_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer; the pointer
// moves to one past the winner when advance is asserted with a live grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant_onehot,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;

  always_comb begin
    int j;
    j            = 0;
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any             = 1'b1;
        grant_idx       = IW'(j);
        grant_onehot[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && any) begin
      ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/gps_round_scheduler.sv
// Time-shares one GPS code generator between NUM_REQ requesters, one round at a time.
//   state    | meaning
//   IDLE     | no round; core reset released
//   ARB      | grant one requester, latch id/sv_num, refuse if key absent
//   CORE_RST | hold core reset for RST_CYCLES cycles
//   START    | single startRound pulse, timeout timer loaded
//   WAIT     | wait for l_code_valid, key loss or timeout
//   RESP     | present response until consumer accepts
module gps_round_scheduler
  import gps_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int RST_CYCLES     = 2
) (
  input  logic                          sys_clk_50,
  input  logic                          sync_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [GPS_SV_NUM_W*NUM_REQ-1:0] req_sv_num,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          key_complete,
  output logic                          gps_rst,
  output logic [GPS_SV_NUM_W-1:0]       gps_sv_num,
  output logic                          gps_start_round,
  input  logic [GPS_CA_W-1:0]           gps_ca_code,
  input  logic [GPS_CODE_W-1:0]         gps_p_code,
  input  logic [GPS_CODE_W-1:0]         gps_l_code,
  input  logic                          gps_l_code_valid,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [1:0]                    rsp_status,
  output logic [GPS_CA_W-1:0]           rsp_ca_code,
  output logic [GPS_CODE_W-1:0]         rsp_p_code,
  output logic [GPS_CODE_W-1:0]         rsp_l_code
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RC_W = $clog2(RST_CYCLES + 1);

  state_t                  state;
  gps_rsp_status_t         status_q;
  logic [RC_W-1:0]         rst_cnt;
  logic [TO_W-1:0]         to_cnt;
  logic [NUM_REQ-1:0]      grant_onehot;
  logic [ID_W-1:0]         grant_idx;
  logic                    any_req;
  logic                    grant_fire;
  logic [GPS_SV_NUM_W-1:0] grant_sv_num;

  // Grant is decided on the live req_valid seen during ARB, so a requester that
  // withdrew in the meantime is never handed a ready pulse.
  assign grant_fire   = (state == ST_ARB) && any_req;
  assign req_ready    = grant_fire ? grant_onehot : '0;
  assign grant_sv_num = req_sv_num[grant_idx*GPS_SV_NUM_W +: GPS_SV_NUM_W];
  assign rsp_status   = status_q;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .clk          (sys_clk_50),
    .rst_n        (sync_rst_n),
    .req          (req_valid),
    .advance      (grant_fire),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (any_req)
  );

  always_ff @(posedge sys_clk_50) begin
    if (!sync_rst_n) begin
      state           <= ST_IDLE;
      gps_rst         <= 1'b1;
      gps_sv_num      <= '0;
      gps_start_round <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_id          <= '0;
      status_q        <= RSP_OK;
      rsp_ca_code     <= '0;
      rsp_p_code      <= '0;
      rsp_l_code      <= '0;
      rst_cnt         <= '0;
      to_cnt          <= '0;
    end else begin
      gps_start_round <= 1'b0;
      case (state)
        ST_IDLE: begin
          gps_rst <= 1'b0;
          if (|req_valid) state <= ST_ARB;
        end

        ST_ARB: begin
          if (!any_req) begin
            state <= ST_IDLE;
          end else begin
            rsp_id     <= grant_idx;
            gps_sv_num <= grant_sv_num;
            if (!key_complete) begin
              status_q    <= RSP_NOKEY;
              rsp_ca_code <= '0;
              rsp_p_code  <= '0;
              rsp_l_code  <= '0;
              rsp_valid   <= 1'b1;
              state       <= ST_RESP;
            end else begin
              gps_rst <= 1'b1;
              rst_cnt <= RC_W'(RST_CYCLES - 1);
              state   <= ST_CORE_RST;
            end
          end
        end

        ST_CORE_RST: begin
          if (rst_cnt == '0) begin
            gps_rst         <= 1'b0;
            gps_start_round <= 1'b1;
            to_cnt          <= TO_W'(TIMEOUT_CYCLES - 1);
            state           <= ST_START;
          end else begin
            rst_cnt <= rst_cnt - RC_W'(1);
          end
        end

        // Timer counts down from the START cycle so it hits zero on the
        // TIMEOUT_CYCLES-1'th cycle after the start pulse.
        ST_START: begin
          to_cnt <= to_cnt - TO_W'(1);
          state  <= ST_WAIT;
        end

        ST_WAIT: begin
          if (gps_l_code_valid) begin
            status_q    <= RSP_OK;
            rsp_ca_code <= gps_ca_code;
            rsp_p_code  <= gps_p_code;
            rsp_l_code  <= gps_l_code;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end else if (!key_complete) begin
            status_q    <= RSP_NOKEY;
            rsp_ca_code <= '0;
            rsp_p_code  <= '0;
            rsp_l_code  <= '0;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end else if (to_cnt == '0) begin
            status_q    <= RSP_TIMEOUT;
            rsp_ca_code <= '0;
            rsp_p_code  <= '0;
            rsp_l_code  <= '0;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end else begin
            to_cnt <= to_cnt - TO_W'(1);
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
